ptp_rtc_adj_sched: RTL and testbench



---
 rtl/ptp_rtc_adj_sched.sv | 188 ++++++++++++++++++
 tb/tb_ptp_rtc_adj_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_rtc_adj_sched.sv
// Schedules SET / STEP / SLEW corrections from two requesters onto the RTC
// load and increment-trim inputs, one command at a time, round-robin arbitrated.
//
//   state | meaning
//   IDLE  | waiting for a request; grants round-robin
//   CALC  | evaluates latched command, computes load value or slew length
//   LOAD  | issues the one-cycle rtc_load pulse
//   SLEW  | trims rtc_inc by +/-1 ns per cycle until remaining hits zero
//   DONE  | pulses done/err for the granted port, clears busy
module ptp_rtc_adj_sched #(
    parameter int unsigned NOM_INC  = 8,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned NS_MAX   = 999999999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] rtc_time,
    output logic        rtc_load,
    output logic [79:0] rtc_load_val,
    output logic [7:0]  rtc_inc,
    input  logic [1:0]  req,
    input  logic [1:0]  cmd0,
    input  logic [1:0]  cmd1,
    input  logic [79:0] val0,
    input  logic [79:0] val1,
    output logic [1:0]  ack,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    input  logic        slew_abort
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_SLEW = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] CMD_SET  = 2'b00;
    localparam logic [1:0] CMD_STEP = 2'b01;
    localparam logic [1:0] CMD_SLEW = 2'b10;

    localparam logic signed [33:0] COMP       = 34'(LOAD_LAT * NOM_INC);
    localparam logic signed [33:0] NS_MAX_S   = 34'(NS_MAX);
    localparam logic signed [33:0] NS_PER_SEC = 34'(NS_MAX + 1);
    localparam logic [32:0]        OFF_LIMIT  = 33'(NS_MAX);

    localparam logic [7:0] INC_NOM  = 8'(NOM_INC);
    localparam logic [7:0] INC_FAST = 8'(NOM_INC + 1);
    localparam logic [7:0] INC_SLOW = 8'(NOM_INC - 1);

    logic [2:0]  state;
    logic        rr_last;
    logic        gnt_q;
    logic [1:0]  cmd_q;
    logic [79:0] val_q;
    logic [79:0] load_val;
    logic [31:0] remaining;
    logic        err_pend;

    logic               g_sel;
    logic [31:0]        off;
    logic signed [32:0] off_ext;
    logic [32:0]        off_abs;
    logic signed [33:0] ns_sum;
    logic signed [33:0] step_ns;
    logic [47:0]        step_sec;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        g_sel = req[1];
        if (req == 2'b11) g_sel = ~rr_last;
    end

    assign off     = val_q[31:0];
    assign off_ext = {off[31], off};
    assign off_abs = off[31] ? 33'(-off_ext) : off_ext;

    // rtc_time is sampled in CALC; the RTC advances LOAD_LAT ticks before the load lands.
    assign ns_sum = $signed({2'b00, rtc_time[31:0]}) + $signed({{2{off[31]}}, off}) + COMP;

    always_comb begin
        step_ns  = ns_sum;
        step_sec = rtc_time[79:32];
        if (ns_sum > NS_MAX_S) begin
            step_ns  = ns_sum - NS_PER_SEC;
            step_sec = rtc_time[79:32] + 48'd1;
        end else if (ns_sum < 34'sd0) begin
            step_ns  = ns_sum + NS_PER_SEC;
            step_sec = rtc_time[79:32] - 48'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_last      <= 1'b1;
            gnt_q        <= 1'b0;
            cmd_q        <= 2'b00;
            val_q        <= '0;
            load_val     <= '0;
            remaining    <= '0;
            err_pend     <= 1'b0;
            rtc_load     <= 1'b0;
            rtc_load_val <= '0;
            rtc_inc      <= INC_NOM;
            ack          <= 2'b00;
            done         <= 2'b00;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ack      <= 2'b00;
            done     <= 2'b00;
            rtc_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q   <= g_sel;
                        rr_last <= g_sel;
                        ack     <= g_sel ? 2'b10 : 2'b01;
                        cmd_q   <= g_sel ? cmd1 : cmd0;
                        val_q   <= g_sel ? val1 : val0;
                        busy    <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    err_pend <= 1'b0;
                    case (cmd_q)
                        CMD_SET: begin
                            load_val <= val_q;
                            state    <= ST_LOAD;
                        end
                        CMD_STEP: begin
                            if (off_abs > OFF_LIMIT) begin
                                err_pend <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                load_val <= {step_sec, step_ns[31:0]};
                                state    <= ST_LOAD;
                            end
                        end
                        CMD_SLEW: begin
                            if (off == 32'd0) begin
                                state <= ST_DONE;
                            end else begin
                                remaining <= off_abs[31:0];
                                rtc_inc   <= off[31] ? INC_SLOW : INC_FAST;
                                state     <= ST_SLEW;
                            end
                        end
                        default: begin
                            err_pend <= 1'b1;
                            state    <= ST_DONE;
                        end
                    endcase
                end
                ST_LOAD: begin
                    rtc_load     <= 1'b1;
                    rtc_load_val <= load_val;
                    state        <= ST_DONE;
                end
                ST_SLEW: begin
                    // Abort wins over a coincident natural finish.
                    if (slew_abort) begin
                        rtc_inc  <= INC_NOM;
                        err_pend <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            rtc_inc <= INC_NOM;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= gnt_q ? 2'b10 : 2'b01;
                    err   <= err_pend;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptp_rtc_adj_sched.sv
// Bench for ptp_rtc_adj_sched: directed and randomized commands checked against
// an arithmetic model of time corrections, arbitration and reset behaviour.
module tb_ptp_rtc_adj_sched;

    localparam int unsigned NOM_INC  = 8;
    localparam int unsigned LOAD_LAT = 2;
    localparam int unsigned NS_MAX   = 999999999;
    localparam logic [7:0]  NOM8     = 8'(NOM_INC);

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] rtc_time;
    logic        rtc_load;
    logic [79:0] rtc_load_val;
    logic [7:0]  rtc_inc;
    logic [1:0]  req;
    logic [1:0]  cmd0, cmd1;
    logic [79:0] val0, val1;
    logic [1:0]  ack, done;
    logic        err, busy;
    logic        slew_abort;

    int n_checks = 0;
    int n_pass   = 0;

    ptp_rtc_adj_sched #(.NOM_INC(NOM_INC), .LOAD_LAT(LOAD_LAT), .NS_MAX(NS_MAX)) dut (
        .clk(clk), .reset(rst), .rtc_time(rtc_time), .rtc_load(rtc_load),
        .rtc_load_val(rtc_load_val), .rtc_inc(rtc_inc), .req(req), .cmd0(cmd0),
        .cmd1(cmd1), .val0(val0), .val1(val1), .ack(ack), .done(done), .err(err),
        .busy(busy), .slew_abort(slew_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference STEP result: plain integer arithmetic on the time fields.
    function automatic void model_step(input logic [79:0] now, input logic [31:0] off,
                                       output logic e, output logic [79:0] res);
        longint o, a, t;
        logic [47:0] s;
        o = longint'($signed(off));
        a = (o < 0) ? -o : o;
        e = (a > longint'(NS_MAX));
        t = longint'(now[31:0]) + o + longint'(LOAD_LAT * NOM_INC);
        s = now[79:32];
        if (t > longint'(NS_MAX)) begin
            t = t - 1000000000;
            s = s + 48'd1;
        end else if (t < 0) begin
            t = t + 1000000000;
            s = s - 48'd1;
        end
        res = {s, t[31:0]};
    endfunction

    task automatic wait_nz(input bit which_done, output logic [1:0] v, output int cyc);
        v   = 2'b00;
        cyc = 0;
        while (v == 2'b00 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            v = which_done ? done : ack;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = 2'b00;
        slew_abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_txn(input int port, input logic [1:0] cmd, input logic [79:0] val,
                           input logic [79:0] now, input int abort_at);
        logic        exp_err, exp_load, e_step, e_obs, busy_d;
        logic [79:0] exp_lval, lval;
        logic [7:0]  exp_inc;
        logic [1:0]  a, dn;
        int          exp_trims, exp_dc, lat, loads, load_c, trims, bad, done_c;
        longint      o, n;

        exp_err = 1'b0; exp_load = 1'b0; exp_lval = '0; exp_inc = NOM8;
        exp_trims = 0; exp_dc = -1;
        case (cmd)
            2'b00: begin exp_load = 1'b1; exp_lval = val; exp_dc = 3; end
            2'b01: begin
                model_step(now, val[31:0], e_step, exp_lval);
                exp_err  = e_step;
                exp_load = !e_step;
                if (!e_step) exp_dc = 3;
            end
            2'b10: begin
                o = longint'($signed(val[31:0]));
                n = (o < 0) ? -o : o;
                if (n != 0) begin
                    exp_inc = (o < 0) ? NOM8 - 8'd1 : NOM8 + 8'd1;
                    if (abort_at > 0 && longint'(abort_at) < n) begin
                        exp_trims = abort_at; exp_err = 1'b1; exp_dc = abort_at + 2;
                    end else begin
                        exp_trims = int'(n); exp_dc = int'(n) + 2;
                    end
                end
            end
            default: exp_err = 1'b1;
        endcase

        rtc_time = now;
        if (port == 0) begin cmd0 = cmd; val0 = val; req = 2'b01; end
        else           begin cmd1 = cmd; val1 = val; req = 2'b10; end
        wait_nz(1'b0, a, lat);
        chk("ack_port", a, (port == 0) ? 2'b01 : 2'b10);
        chk("ack_lat", lat, 1);
        req = 2'b00;

        loads = 0; load_c = -1; lval = '0; trims = 0; bad = 0; done_c = -1;
        dn = 2'b00; e_obs = 1'bx; busy_d = 1'bx;
        for (int k = 1; k <= 300 && done_c < 0; k++) begin
            @(negedge clk);
            if (rtc_load) begin loads++; load_c = k; lval = rtc_load_val; end
            if (rtc_inc !== NOM8) begin
                trims++;
                if (rtc_inc !== exp_inc) bad++;
            end
            if (done != 2'b00) begin done_c = k; dn = done; e_obs = err; busy_d = busy; end
            slew_abort = (k == abort_at);
        end
        slew_abort = 1'b0;

        chk("done_port", dn, (port == 0) ? 2'b01 : 2'b10);
        chk("err", e_obs, exp_err);
        chk("busy_at_done", busy_d, 1'b0);
        chk("load_count", loads, exp_load ? 1 : 0);
        if (exp_load) begin
            chk("load_val", lval, exp_lval);
            chk("load_lat", load_c, 2);
        end
        if (exp_dc >= 0) chk("done_lat", done_c, exp_dc);
        chk("trim_cycles", trims, exp_trims);
        chk("trim_value_bad", bad, 0);
        @(negedge clk);
        chk("err_hold", err, exp_err);
    endtask

    initial begin
        logic [1:0]  v;
        int          cyc, dcount, lcount, abort_k, port;
        logic [1:0]  cmd;
        logic [31:0] off;
        logic [79:0] now, sv;
        int unsigned m;

        rtc_time = '0; cmd0 = 2'b00; cmd1 = 2'b00; val0 = '0; val1 = '0;
        do_reset();
        chk("rst_load", rtc_load, 1'b0);
        chk("rst_load_val", rtc_load_val, 80'd0);
        chk("rst_inc", rtc_inc, NOM8);
        chk("rst_ack", ack, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);

        run_txn(0, 2'b00, {48'd5, 32'd100}, {48'd9, 32'd9}, 0);
        run_txn(1, 2'b01, {48'd0, 32'd999999000}, {48'd7, 32'd500}, 0);
        run_txn(1, 2'b01, {48'd0, 32'd1000}, {48'd7, 32'd999999000}, 0);
        run_txn(0, 2'b01, {48'd0, 32'(-600)}, {48'd3, 32'd100}, 0);
        run_txn(0, 2'b01, {48'd0, 32'd1000000000}, {48'd3, 32'd100}, 0);
        run_txn(1, 2'b01, {48'd0, 32'(-999999999)}, {48'd0, 32'd0}, 0);
        run_txn(1, 2'b10, {48'd0, 32'(-3)}, {48'd1, 32'd1}, 0);
        run_txn(0, 2'b10, {48'd0, 32'd100}, {48'd1, 32'd1}, 10);
        run_txn(1, 2'b10, 80'd0, {48'd1, 32'd1}, 0);
        run_txn(0, 2'b11, {48'd1, 32'd1}, {48'd1, 32'd1}, 0);

        for (int i = 0; i < 40; i++) begin
            port = int'($urandom_range(1, 0));
            cmd  = 2'($urandom_range(3, 0));
            now  = {16'($urandom), $urandom, 32'($urandom_range(NS_MAX, 0))};
            if ($urandom_range(7, 0) == 0) now[79:32] = '0;
            abort_k = 0;
            case (cmd)
                2'b00: sv = {16'($urandom), $urandom, $urandom};
                2'b01: begin
                    m   = $urandom_range(1100000000, 0);
                    off = ($urandom_range(1, 0) == 1) ? 32'(-m) : m;
                    sv  = {48'($urandom), off};
                end
                2'b10: begin
                    m   = $urandom_range(20, 0);
                    off = ($urandom_range(1, 0) == 1) ? 32'(-m) : m;
                    sv  = {48'($urandom), off};
                    if (m >= 2 && $urandom_range(3, 0) == 0) abort_k = int'($urandom_range(m - 1, 1));
                end
                default: sv = {16'($urandom), $urandom, $urandom};
            endcase
            run_txn(port, cmd, sv, now, abort_k);
        end

        // Tied requests from reset: grants alternate and no requester is lost.
        do_reset();
        cmd0 = 2'b00; val0 = {48'd11, 32'd1};
        cmd1 = 2'b00; val1 = {48'd22, 32'd2};
        req  = 2'b11;
        wait_nz(1'b0, v, cyc); chk("rr_ack_1", v, 2'b01);
        req[0] = 1'b0;
        wait_nz(1'b1, v, cyc); chk("rr_done_1", v, 2'b01);
        wait_nz(1'b0, v, cyc); chk("rr_ack_2", v, 2'b10);
        req = 2'b01;
        wait_nz(1'b1, v, cyc); chk("rr_done_2", v, 2'b10);
        wait_nz(1'b0, v, cyc); chk("rr_ack_3", v, 2'b01);
        req = 2'b00;
        wait_nz(1'b1, v, cyc); chk("rr_done_3", v, 2'b01);
        chk("rr_last_load", rtc_load_val, {48'd11, 32'd1});

        // Reset in the middle of a slew.
        @(negedge clk);
        cmd1 = 2'b10; val1 = {48'd0, 32'd50}; req = 2'b10;
        wait_nz(1'b0, v, cyc); chk("mid_ack", v, 2'b10);
        req = 2'b00;
        repeat (5) @(negedge clk);
        chk("mid_trim", rtc_inc, NOM8 + 8'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_inc", rtc_inc, NOM8);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dcount = 0; lcount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done != 2'b00) dcount++;
            if (rtc_load) lcount++;
            if (rtc_inc !== NOM8) dcount++;
        end
        chk("mid_no_done", dcount, 0);
        chk("mid_no_load", lcount, 0);
        run_txn(0, 2'b00, {48'd77, 32'd123}, {48'd1, 32'd1}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
